// File: rtl/jt900h_busarb_pkg.sv
// Shared types for the jt900h external RAM arbiter: FSM states and owner codes.
package jt900h_busarb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      ACC  = 1'b1
   } state_t;

   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_DMA = 1'b1;

endpackage

// File: rtl/jt900h_busarb_pick.sv
// Combinational winner selection between the CPU and micro-DMA ports.
module jt900h_busarb_pick
   import jt900h_busarb_pkg::*;
(
   input  logic cpu_elig,
   input  logic dma_elig,
   input  logic dma_pri,
   input  logic rr_last,
   output logic valid,
   output logic winner
);

   // On contention either DMA has fixed priority or the port not served last wins.
   always_comb begin
      valid  = cpu_elig | dma_elig;
      winner = OWN_CPU;
      if (cpu_elig && dma_elig) begin
         winner = dma_pri ? OWN_DMA : ~rr_last;
      end else if (dma_elig) begin
         winner = OWN_DMA;
      end
   end

endmodule

// File: rtl/jt900h_busarb.sv
// Two-port arbiter for the single 16-bit external RAM: CPU memory controller vs micro-DMA.
module jt900h_busarb
   import jt900h_busarb_pkg::*;
#(
   parameter int AW = 24,
   parameter int WW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cen,
   input  logic          cpu_req,
   input  logic [AW-1:0] cpu_addr,
   input  logic [15:0]   cpu_din,
   input  logic [1:0]    cpu_we,
   output logic          cpu_ack,
   output logic [15:0]   cpu_dout,
   input  logic          dma_req,
   input  logic [AW-1:0] dma_addr,
   input  logic [15:0]   dma_din,
   input  logic [1:0]    dma_we,
   output logic          dma_ack,
   output logic [15:0]   dma_dout,
   input  logic          dma_pri,
   input  logic [WW-1:0] wait_cfg,
   output logic [AW-1:0] ram_addr,
   output logic [15:0]   ram_din,
   output logic [1:0]    ram_we,
   output logic          ram_cs,
   input  logic [15:0]   ram_dout,
   input  logic          ram_ok,
   output logic          owner
);

   state_t        state, next_state;
   logic [WW-1:0] cnt;
   logic          rr_ptr, rr_seen, rr_last;
   logic          cpu_elig, dma_elig, pick_valid, pick_winner;
   logic          grant, done;

   // A port still seeing its ack is excluded so a late req drop cannot cause a double grant.
   assign cpu_elig = cpu_req & ~cpu_ack;
   assign dma_elig = dma_req & ~dma_ack;
   // Until the first completion the CPU is treated as favoured on a tie.
   assign rr_last  = rr_seen ? rr_ptr : OWN_DMA;

   jt900h_busarb_pick u_pick (
      .cpu_elig (cpu_elig),
      .dma_elig (dma_elig),
      .dma_pri  (dma_pri),
      .rr_last  (rr_last),
      .valid    (pick_valid),
      .winner   (pick_winner)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)      state <= IDLE;
      else if (cen) state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (pick_valid)           next_state = ACC;
         ACC:  if (cnt == '0 && ram_ok)  next_state = IDLE;
      endcase
   end

   always_comb begin
      grant = (state == IDLE) && pick_valid;
      done  = (state == ACC) && (cnt == '0) && ram_ok;
   end

   // Bus-cycle datapath: latch on grant, count waits, finish when ready.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         rr_ptr   <= OWN_CPU;
         rr_seen  <= 1'b0;
         owner    <= OWN_CPU;
         ram_addr <= '0;
         ram_din  <= '0;
         ram_we   <= '0;
         ram_cs   <= 1'b0;
         cpu_ack  <= 1'b0;
         dma_ack  <= 1'b0;
         cpu_dout <= '0;
         dma_dout <= '0;
      end else if (cen) begin
         cpu_ack <= 1'b0;
         dma_ack <= 1'b0;
         if (grant) begin
            ram_addr <= pick_winner ? dma_addr : cpu_addr;
            ram_din  <= pick_winner ? dma_din  : cpu_din;
            ram_we   <= pick_winner ? dma_we   : cpu_we;
            ram_cs   <= 1'b1;
            owner    <= pick_winner;
            cnt      <= wait_cfg;
         end else if (state == ACC && cnt != '0) begin
            cnt <= cnt - WW'(1);
         end else if (done) begin
            if (ram_we == 2'b00) begin
               if (owner == OWN_DMA) dma_dout <= ram_dout;
               else                  cpu_dout <= ram_dout;
            end
            if (owner == OWN_DMA) dma_ack <= 1'b1;
            else                  cpu_ack <= 1'b1;
            ram_cs  <= 1'b0;
            ram_we  <= 2'b00;
            rr_ptr  <= owner;
            rr_seen <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_jt900h_busarb.sv
// Self-checking bench for jt900h_busarb: directed scenarios plus randomized traffic vs a transaction model.
module tb_jt900h_busarb;

   localparam int AW = 24;
   localparam int WW = 3;

   logic          clk = 1'b0;
   logic          rst, cen;
   logic          cpu_req, dma_req, dma_pri, ram_ok;
   logic [AW-1:0] cpu_addr, dma_addr;
   logic [15:0]   cpu_din, dma_din, ram_dout;
   logic [1:0]    cpu_we, dma_we;
   logic [WW-1:0] wait_cfg;
   logic          cpu_ack, dma_ack, ram_cs, owner;
   logic [15:0]   cpu_dout, dma_dout, ram_din;
   logic [AW-1:0] ram_addr;
   logic [1:0]    ram_we;

   int n_checks = 0;
   int n_fail   = 0;

   jt900h_busarb #(.AW(AW), .WW(WW)) dut (
      .clk(clk), .rst(rst), .cen(cen),
      .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_we(cpu_we),
      .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
      .dma_req(dma_req), .dma_addr(dma_addr), .dma_din(dma_din), .dma_we(dma_we),
      .dma_ack(dma_ack), .dma_dout(dma_dout),
      .dma_pri(dma_pri), .wait_cfg(wait_cfg),
      .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_cs(ram_cs),
      .ram_dout(ram_dout), .ram_ok(ram_ok), .owner(owner)
   );

   always #5 clk = ~clk;

   // Transaction-level model: one pending access at a time, with cycles left before it may finish.
   logic          m_busy, m_owner, m_cs, m_last, m_seen;
   int            m_left;
   logic [AW-1:0] m_addr;
   logic [15:0]   m_din;
   logic [1:0]    m_we;
   logic [1:0]    m_ack;
   logic [15:0]   m_dout [2];

   task automatic model_reset();
      m_busy = 0; m_owner = 0; m_cs = 0; m_last = 0; m_seen = 0; m_left = 0;
      m_addr = '0; m_din = '0; m_we = '0; m_ack = '0;
      m_dout[0] = '0; m_dout[1] = '0;
   endtask

   task automatic model_edge();
      logic [1:0] seen_ack;
      logic       e_cpu, e_dma, w;
      seen_ack = m_ack;
      m_ack = 2'b00;
      if (!m_busy) begin
         e_cpu = cpu_req && !seen_ack[0];
         e_dma = dma_req && !seen_ack[1];
         if (e_cpu || e_dma) begin
            if (e_cpu && e_dma) w = dma_pri ? 1'b1 : (m_seen ? !m_last : 1'b0);
            else                w = e_dma;
            m_owner = w;
            m_addr  = w ? dma_addr : cpu_addr;
            m_din   = w ? dma_din  : cpu_din;
            m_we    = w ? dma_we   : cpu_we;
            m_cs    = 1;
            m_left  = int'(wait_cfg);
            m_busy  = 1;
         end
      end else if (m_left > 0) begin
         m_left--;
      end else if (ram_ok) begin
         if (m_we == 2'b00) m_dout[int'(m_owner)] = ram_dout;
         m_ack[int'(m_owner)] = 1'b1;
         m_cs = 0; m_we = 2'b00;
         m_last = m_owner; m_seen = 1; m_busy = 0;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkOutput();
      chk("cpu_ack",  32'(cpu_ack),  32'(m_ack[0]));
      chk("dma_ack",  32'(dma_ack),  32'(m_ack[1]));
      chk("cpu_dout", 32'(cpu_dout), 32'(m_dout[0]));
      chk("dma_dout", 32'(dma_dout), 32'(m_dout[1]));
      chk("ram_cs",   32'(ram_cs),   32'(m_cs));
      chk("ram_we",   32'(ram_we),   32'(m_we));
      chk("ram_addr", 32'(ram_addr), 32'(m_addr));
      chk("ram_din",  32'(ram_din),  32'(m_din));
      chk("owner",    32'(owner),    32'(m_owner));
   endtask

   task automatic step();
      @(posedge clk);
      if (!rst && cen) model_edge();
      @(negedge clk);
      checkOutput();
   endtask

   task automatic assert_reset();
      rst = 1'b1;
      model_reset();
      #1;
      checkOutput();
   endtask

   // Random requester: raise with fresh data, drop after ack, occasionally withdraw.
   task automatic applyStimulus(input logic ack, inout logic req, inout logic [AW-1:0] addr,
                                inout logic [15:0] din, inout logic [1:0] we);
      if (req && ack) begin
         if ($urandom_range(0, 3) != 0) req = 1'b0;
      end else if (!req) begin
         if ($urandom_range(0, 2) == 0) begin
            req  = 1'b1;
            addr = AW'($urandom);
            din  = 16'($urandom);
            we   = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom);
         end
      end else if ($urandom_range(0, 19) == 0) begin
         req = 1'b0;
      end
   endtask

   initial begin
      int grants, cnt_en, idle_gap;
      logic [3:0] gseq;
      logic [15:0] last_val;
      logic prev_cs;

      rst = 1; cen = 1; cpu_req = 0; dma_req = 0; dma_pri = 0; ram_ok = 1;
      cpu_addr = '0; dma_addr = '0; cpu_din = '0; dma_din = '0; cpu_we = '0; dma_we = '0;
      wait_cfg = '0; ram_dout = '0;
      model_reset();
      repeat (2) @(negedge clk);
      checkOutput();
      rst = 0;
      step();
      chk("reset ram_cs", 32'(ram_cs), 0);
      chk("reset owner", 32'(owner), 0);

      // CPU read, no waits.
      cpu_req = 1; cpu_addr = 24'h001234; cpu_we = 2'b00; ram_dout = 16'hBEEF;
      step();
      chk("t1 grant cs", 32'(ram_cs), 1);
      chk("t1 grant addr", 32'(ram_addr), 32'h001234);
      step();
      chk("t1 cpu_ack", 32'(cpu_ack), 1);
      chk("t1 cpu_dout", 32'(cpu_dout), 32'hBEEF);
      chk("t1 cs off", 32'(ram_cs), 0);
      chk("t1 dma_ack", 32'(dma_ack), 0);
      cpu_req = 0;
      step();
      chk("t1 ack pulse", 32'(cpu_ack), 0);

      // DMA write with three wait states; wait_cfg changed mid-access must not matter.
      dma_req = 1; dma_addr = 24'h200001; dma_we = 2'b10; dma_din = 16'hAA55; wait_cfg = 3;
      step();
      wait_cfg = 0;
      chk("t2 we 0", 32'(ram_we), 32'h2);
      for (int i = 1; i < 4; i++) begin
         step();
         chk("t2 we held", 32'(ram_we), 32'h2);
         chk("t2 no ack", 32'(dma_ack), 0);
      end
      step();
      chk("t2 dma_ack", 32'(dma_ack), 1);
      chk("t2 we clr", 32'(ram_we), 0);
      chk("t2 owner", 32'(owner), 1);
      dma_req = 0;
      step();

      // ram_ok low stalls completion.
      cpu_req = 1; cpu_addr = 24'h000100; cpu_we = 2'b00; ram_ok = 0; ram_dout = 16'h1357;
      step();
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t4 stall ack", 32'(cpu_ack), 0);
         chk("t4 stall cs", 32'(ram_cs), 1);
      end
      ram_ok = 1;
      step();
      chk("t4 ack", 32'(cpu_ack), 1);
      chk("t4 dout", 32'(cpu_dout), 32'h1357);
      cpu_req = 0;
      step();

      // Reset during a DMA access, then round-robin from reset state.
      dma_req = 1; dma_addr = 24'h000444; dma_we = 2'b11; dma_din = 16'h4444; wait_cfg = 3;
      step();
      step();
      assert_reset();
      chk("t5 cs", 32'(ram_cs), 0);
      chk("t5 we", 32'(ram_we), 0);
      chk("t5 owner", 32'(owner), 0);
      chk("t5 dma_ack", 32'(dma_ack), 0);
      step();
      rst = 0; wait_cfg = 0; dma_pri = 0;
      cpu_req = 1; cpu_we = 2'b00; cpu_addr = 24'h000010;
      grants = 0; gseq = '0; prev_cs = 0; idle_gap = 0;
      for (int i = 0; i < 40 && grants < 4; i++) begin
         step();
         if (ram_cs && !prev_cs) begin
            gseq[grants] = owner;
            if (grants > 0) chk("t3 idle gap", 32'(idle_gap), 1);
            grants++;
            idle_gap = 0;
         end else if (!ram_cs) begin
            idle_gap++;
         end
         prev_cs = ram_cs;
      end
      chk("t3 grant count", 32'(grants), 4);
      chk("t3 order", 32'(gseq), 32'b1010);
      cpu_req = 0; dma_req = 0;
      step();
      chk("t3 dropped req ack", 32'(dma_ack), 1);
      step();

      // Fixed priority: DMA wins even though CPU is next in round-robin.
      dma_pri = 1; cpu_req = 1; dma_req = 1;
      step();
      chk("t3 pri owner", 32'(owner), 1);
      chk("t3 pri cs", 32'(ram_cs), 1);
      cpu_req = 0; dma_req = 0; dma_pri = 0;
      step(); step();

      // cen toggling during a two-wait DMA read.
      dma_req = 1; dma_addr = 24'h000800; dma_we = 2'b00; wait_cfg = 2;
      step();
      cnt_en = 0; last_val = '0;
      for (int i = 0; i < 20 && !dma_ack; i++) begin
         cen = (i % 2 == 1);
         ram_dout = 16'($urandom);
         if (cen) last_val = ram_dout;
         step();
         if (cen) cnt_en++;
      end
      chk("t6 enabled cycles", 32'(cnt_en), 3);
      chk("t6 dma_ack", 32'(dma_ack), 1);
      chk("t6 dma_dout", 32'(dma_dout), 32'(last_val));
      cen = 1; dma_req = 0;
      step();

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         if (rst) rst = 0;
         cen      = ($urandom_range(0, 3) != 0);
         ram_ok   = ($urandom_range(0, 4) != 0);
         ram_dout = 16'($urandom);
         wait_cfg = WW'($urandom_range(0, 3));
         if ($urandom_range(0, 49) == 0) dma_pri = ~dma_pri;
         applyStimulus(m_ack[0], cpu_req, cpu_addr, cpu_din, cpu_we);
         applyStimulus(m_ack[1], dma_req, dma_addr, dma_din, dma_we);
         if ($urandom_range(0, 299) == 0) assert_reset();
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
